// File: rtl/bali_mem_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bali_mem_pkg
// Description : Shared types and constants for the loadable program memory:
//               loader FSM states, header/constant widths, byte type.
// Revision    : 1.0 - initial release
// ============================================================================
package bali_mem_pkg;

    // Length prefix on the load stream is two bytes, big-endian
    localparam int HDR_BYTES   = 2;
    localparam int LEN_W       = 8 * HDR_BYTES;

    // Constant-pool entries are 32-bit big-endian words
    localparam int CONST_BYTES = 4;

    typedef logic [7:0] byte_t;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_HDR_HI = 3'd1,
        ST_HDR_LO = 3'd2,
        ST_DATA   = 3'd3,
        ST_READY  = 3'd4
    } load_state_t;

endpackage
`default_nettype wire

// File: rtl/progmem_loader.sv
`default_nettype none
// ============================================================================
// Module      : progmem_loader
// Description : Parses the length-prefixed load stream, generates memory
//               write strobes, tracks byte count, overflow error and the
//               program-complete flag.
// Revision    : 1.0 - initial release
// ============================================================================
module progmem_loader
    import bali_mem_pkg::*;
#(
    parameter int SIZE   = 65536,
    parameter int PC_LEN = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_start,
    input  logic              load_valid,
    input  logic [7:0]        load_byte,
    output logic              loaded,
    output logic              load_err,
    output logic [PC_LEN:0]   load_count,
    output logic              wr_en,
    output logic [PC_LEN-1:0] wr_addr,
    output logic [7:0]        wr_data
);

    // The counter must reach any declared length even when SIZE is small,
    // so it is at least one bit wider than the length field.
    localparam int CNT_W = (PC_LEN + 1 > LEN_W + 1) ? PC_LEN + 1 : LEN_W + 1;

    load_state_t      state;
    logic [LEN_W-1:0] len;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;
    logic             take;
    logic             in_range;

    // A byte arriving together with load_start is dropped
    assign take       = load_valid && !load_start;
    assign cnt_next   = cnt + CNT_W'(1);
    assign in_range   = (cnt < CNT_W'(SIZE));

    assign wr_en      = (state == ST_DATA) && take && in_range;
    assign wr_addr    = cnt[PC_LEN-1:0];
    assign wr_data    = load_byte;
    assign load_count = cnt[PC_LEN:0];

    // Loader FSM: header parse, payload count, overflow and completion flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            len      <= '0;
            cnt      <= '0;
            loaded   <= 1'b0;
            load_err <= 1'b0;
        end else if (load_start) begin
            state    <= ST_HDR_HI;
            cnt      <= '0;
            loaded   <= 1'b0;
            load_err <= 1'b0;
        end else begin
            case (state)
                ST_HDR_HI: begin
                    if (load_valid) begin
                        len[LEN_W-1 -: 8] <= load_byte;
                        state             <= ST_HDR_LO;
                    end
                end
                ST_HDR_LO: begin
                    if (load_valid) begin
                        len[7:0] <= load_byte;
                        if ({len[LEN_W-1 -: 8], load_byte} == '0) begin
                            state  <= ST_READY;
                            loaded <= 1'b1;
                        end else begin
                            state  <= ST_DATA;
                        end
                    end
                end
                ST_DATA: begin
                    if (load_valid) begin
                        cnt <= cnt_next;
                        if (!in_range) begin
                            load_err <= 1'b1;
                        end
                        if (cnt_next == CNT_W'(len)) begin
                            state  <= ST_READY;
                            loaded <= 1'b1;
                        end
                    end
                end
                default: begin
                    // IDLE and READY ignore stream bytes
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/progmem_ctl.sv
`default_nettype none
// ============================================================================
// Module      : progmem_ctl
// Description : Loadable program/constant memory. Byte storage written by the
//               loader, plus registered opcode fetch and 32-bit constant-pool
//               read ports enabled once a program is complete.
// Revision    : 1.0 - initial release
// ============================================================================
module progmem_ctl
    import bali_mem_pkg::*;
#(
    parameter  int SIZE          = 65536,
    parameter  int FETCH_BYTES   = 3,
    parameter  int CONST_BASE    = 0,
    parameter  int CONST_ENTRIES = 256,
    localparam int PC_LEN        = $clog2(SIZE),
    localparam int IDX_W         = $clog2(CONST_ENTRIES)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     load_start,
    input  logic                     load_valid,
    input  logic [7:0]               load_byte,
    output logic                     loaded,
    output logic                     load_err,
    output logic [PC_LEN:0]          load_count,
    input  logic                     fetch_req,
    input  logic [PC_LEN-1:0]        pc,
    output logic                     fetch_valid,
    output logic [8*FETCH_BYTES-1:0] fetch_bytes,
    input  logic                     const_req,
    input  logic [IDX_W-1:0]         const_index,
    output logic                     const_valid,
    output logic [31:0]              const_data
);

    logic              wr_en;
    logic [PC_LEN-1:0] wr_addr;
    logic [7:0]        wr_data;

    byte_t mem [SIZE];

    logic [8*FETCH_BYTES-1:0] fetch_word;
    logic [8*CONST_BYTES-1:0] const_word;
    logic [PC_LEN+1:0]        const_addr;
    logic [PC_LEN-1:0]        const_start;

    progmem_loader #(
        .SIZE   (SIZE),
        .PC_LEN (PC_LEN)
    ) u_loader (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_start (load_start),
        .load_valid (load_valid),
        .load_byte  (load_byte),
        .loaded     (loaded),
        .load_err   (load_err),
        .load_count (load_count),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data)
    );

    // Byte storage; contents survive reset
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Fetch bytes: opcode at pc in the MSB, following bytes wrap modulo SIZE
    generate
        for (genvar k = 0; k < FETCH_BYTES; k++) begin : g_fetch
            logic [PC_LEN-1:0] addr;
            assign addr = PC_LEN'(({1'b0, pc} + (PC_LEN+1)'(k)) % (PC_LEN+1)'(SIZE));
            assign fetch_word[8*(FETCH_BYTES-1-k) +: 8] = mem[addr];
        end
    endgenerate

    // Entry address computed PC_LEN+2 bits wide, then folded into the memory
    assign const_addr  = (PC_LEN+2)'(CONST_BASE)
                       + (PC_LEN+2)'(const_index) * (PC_LEN+2)'(CONST_BYTES);
    assign const_start = PC_LEN'(const_addr % (PC_LEN+2)'(SIZE));

    generate
        for (genvar j = 0; j < CONST_BYTES; j++) begin : g_const
            logic [PC_LEN-1:0] addr;
            assign addr = PC_LEN'(({1'b0, const_start} + (PC_LEN+1)'(j)) % (PC_LEN+1)'(SIZE));
            assign const_word[8*(CONST_BYTES-1-j) +: 8] = mem[addr];
        end
    endgenerate

    // Registered read ports, served only while a complete program is held
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_valid <= 1'b0;
            fetch_bytes <= '0;
            const_valid <= 1'b0;
            const_data  <= '0;
        end else begin
            fetch_valid <= fetch_req && loaded;
            const_valid <= const_req && loaded;
            if (fetch_req && loaded) begin
                fetch_bytes <= fetch_word;
            end
            if (const_req && loaded) begin
                const_data <= const_word;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_progmem_ctl.sv
`default_nettype none
// ============================================================================
// Module      : tb_progmem_ctl
// Description : Scoreboard bench for progmem_ctl (SIZE=16, FETCH_BYTES=3).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_progmem_ctl;

    localparam int SIZE = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        load_start = 1'b0;
    logic        load_valid = 1'b0;
    logic [7:0]  load_byte = 8'h00;
    logic        loaded;
    logic        load_err;
    logic [4:0]  load_count;
    logic        fetch_req = 1'b0;
    logic [3:0]  pc = 4'h0;
    logic        fetch_valid;
    logic [23:0] fetch_bytes;
    logic        const_req = 1'b0;
    logic [7:0]  const_index = 8'h00;
    logic        const_valid;
    logic [31:0] const_data;

    int vectors = 0;
    int miscompares = 0;

    logic [7:0]  model [SIZE];
    logic [23:0] fq [$];
    logic [31:0] cq [$];
    logic [23:0] fexp;
    logic [31:0] cexp;

    progmem_ctl #(
        .SIZE          (SIZE),
        .FETCH_BYTES   (3),
        .CONST_BASE    (0),
        .CONST_ENTRIES (256)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .load_start  (load_start),
        .load_valid  (load_valid),
        .load_byte   (load_byte),
        .loaded      (loaded),
        .load_err    (load_err),
        .load_count  (load_count),
        .fetch_req   (fetch_req),
        .pc          (pc),
        .fetch_valid (fetch_valid),
        .fetch_bytes (fetch_bytes),
        .const_req   (const_req),
        .const_index (const_index),
        .const_valid (const_valid),
        .const_data  (const_data)
    );

    always #5 clk = ~clk;

    function automatic logic [23:0] exp_fetch(input int p);
        return {model[p % SIZE], model[(p + 1) % SIZE], model[(p + 2) % SIZE]};
    endfunction

    function automatic logic [31:0] exp_const(input int idx);
        int a;
        a = ((4 * idx) % (4 * SIZE)) % SIZE;
        return {model[a], model[(a + 1) % SIZE], model[(a + 2) % SIZE], model[(a + 3) % SIZE]};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        load_valid = 1'b1;
        load_byte  = b;
        tick();
        load_valid = 1'b0;
    endtask

    task automatic send_data(input logic [7:0] b, input int addr);
        if (addr < SIZE) model[addr] = b;
        send_byte(b);
    endtask

    task automatic start_load(input logic [15:0] len);
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
        send_byte(len[15:8]);
        send_byte(len[7:0]);
    endtask

    // Drive one request cycle; expectations are queued only when it should be served
    task automatic issue(input bit f, input int p, input bit c, input int idx, input bit served);
        fetch_req   = f;
        pc          = 4'(p);
        const_req   = c;
        const_index = 8'(idx);
        if (served && f) fq.push_back(exp_fetch(p));
        if (served && c) cq.push_back(exp_const(idx));
        tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        tick();
        vectors++;
        if ({loaded, load_err, load_count, fetch_valid, const_valid} !== 9'h0) begin
            miscompares++;
            $display("FAIL reset_flags got %b want 0", {loaded, load_err, load_count, fetch_valid, const_valid});
        end
        vectors++;
        if (fetch_bytes !== 24'h0 || const_data !== 32'h0) begin
            miscompares++;
            $display("FAIL reset_data got %h/%h want 0/0", fetch_bytes, const_data);
        end
        rst_n = 1'b1;
        tick();
        issue(1, 0, 1, 0, 0);
        fetch_req = 1'b0;
        const_req = 1'b0;
        vectors++;
        if (fetch_valid !== 1'b0 || const_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL idle_req got %b%b want 00", fetch_valid, const_valid);
        end
    endtask

    task automatic test_basic_load();
        start_load(16'h0004);
        send_data(8'hAA, 0);
        send_data(8'hBB, 1);
        send_data(8'hCC, 2);
        vectors++;
        if (loaded !== 1'b0) begin
            miscompares++;
            $display("FAIL basic_early_loaded got %b want 0", loaded);
        end
        send_data(8'hDD, 3);
        vectors++;
        if (loaded !== 1'b1 || load_count !== 5'd4) begin
            miscompares++;
            $display("FAIL basic_loaded got %b/%0d want 1/4", loaded, load_count);
        end
        issue(1, 1, 0, 0, 1);
        fetch_req = 1'b0;
        vectors++;
        if (fetch_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL basic_fetch_valid got %b want 1", fetch_valid);
        end else begin
            fexp = fq.pop_front();
            if (fetch_bytes !== fexp || fexp !== 24'hBBCCDD) begin
                miscompares++;
                $display("FAIL basic_fetch got %h want %h", fetch_bytes, fexp);
            end
        end
        tick();
        vectors++;
        if (fetch_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL basic_pulse got %b want 0", fetch_valid);
        end
    endtask

    task automatic test_back_to_back();
        int pcs  [4] = '{2, 3, 4, 5};
        int idxs [4] = '{0, 4, 5, 17};
        start_load(16'h0008);
        for (int i = 0; i < 8; i++) send_data(8'(i), i);
        issue(1, 0, 1, 1, 1);
        vectors++;
        if (fetch_valid !== 1'b1 || const_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL concurrent_valid got %b%b want 11", fetch_valid, const_valid);
        end else begin
            fexp = fq.pop_front();
            cexp = cq.pop_front();
            if (fetch_bytes !== fexp || const_data !== cexp || cexp !== 32'h04050607) begin
                miscompares++;
                $display("FAIL concurrent_data got %h/%h want %h/%h", fetch_bytes, const_data, fexp, cexp);
            end
        end
        for (int i = 0; i < 4; i++) begin
            issue(1, pcs[i], 1, idxs[i], 1);
            vectors++;
            if (fetch_valid !== 1'b1 || const_valid !== 1'b1) begin
                miscompares++;
                $display("FAIL b2b_valid[%0d] got %b%b want 11", i, fetch_valid, const_valid);
            end else begin
                fexp = fq.pop_front();
                cexp = cq.pop_front();
                if (fetch_bytes !== fexp || const_data !== cexp) begin
                    miscompares++;
                    $display("FAIL b2b_data[%0d] got %h/%h want %h/%h", i, fetch_bytes, const_data, fexp, cexp);
                end
            end
        end
        fetch_req = 1'b0;
        const_req = 1'b0;
        tick();
        vectors++;
        if (fetch_valid !== 1'b0 || const_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL b2b_end got %b%b want 00", fetch_valid, const_valid);
        end
    endtask

    task automatic test_overflow();
        start_load(16'h0014);
        for (int i = 0; i < 20; i++) begin
            send_data(8'h30 + 8'(i), i);
            if (i == 15 || i == 16) begin
                vectors++;
                if (load_err !== (i == 16)) begin
                    miscompares++;
                    $display("FAIL ovf_err[%0d] got %b want %b", i, load_err, (i == 16));
                end
            end
            if (i == 18) begin
                vectors++;
                if (loaded !== 1'b0) begin
                    miscompares++;
                    $display("FAIL ovf_early_loaded got %b want 0", loaded);
                end
            end
        end
        vectors++;
        if (loaded !== 1'b1 || load_count !== 5'd20 || load_err !== 1'b1) begin
            miscompares++;
            $display("FAIL ovf_done got %b/%0d/%b want 1/20/1", loaded, load_count, load_err);
        end
        issue(1, 15, 0, 0, 1);
        fetch_req = 1'b0;
        vectors++;
        if (fetch_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL ovf_fetch_valid got %b want 1", fetch_valid);
        end else begin
            fexp = fq.pop_front();
            if (fetch_bytes !== fexp || fexp !== 24'h3F3031) begin
                miscompares++;
                $display("FAIL ovf_wrap got %h want %h", fetch_bytes, fexp);
            end
        end
    endtask

    task automatic test_no_queue();
        start_load(16'h0005);
        send_data(8'h70, 0);
        send_data(8'h71, 1);
        fetch_req = 1'b1;
        const_req = 1'b1;
        send_data(8'h72, 2);
        vectors++;
        if (fetch_valid !== 1'b0 || const_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL data_req got %b%b want 00", fetch_valid, const_valid);
        end
        tick();
        fetch_req = 1'b0;
        const_req = 1'b0;
        vectors++;
        if (fetch_valid !== 1'b0 || const_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL data_req_hold got %b%b want 00", fetch_valid, const_valid);
        end
        send_data(8'h73, 3);
        send_data(8'h74, 4);
        vectors++;
        if (loaded !== 1'b1 || load_count !== 5'd5) begin
            miscompares++;
            $display("FAIL nq_loaded got %b/%0d want 1/5", loaded, load_count);
        end
        start_load(16'h0000);
        vectors++;
        if (loaded !== 1'b1 || load_count !== 5'd0) begin
            miscompares++;
            $display("FAIL empty_load got %b/%0d want 1/0", loaded, load_count);
        end
    endtask

    task automatic test_reset_mid();
        start_load(16'h0006);
        for (int i = 0; i < 3; i++) send_data(8'h80 + 8'(i), i);
        vectors++;
        if (load_count !== 5'd3) begin
            miscompares++;
            $display("FAIL mid_count got %0d want 3", load_count);
        end
        rst_n = 1'b0;
        #1;
        vectors++;
        if (loaded !== 1'b0 || load_count !== 5'd0) begin
            miscompares++;
            $display("FAIL async_reset got %b/%0d want 0/0", loaded, load_count);
        end
        tick();
        rst_n = 1'b1;
        tick();
        start_load(16'h0006);
        for (int i = 0; i < 6; i++) send_data(8'h90 + 8'(i), i);
        issue(1, 3, 0, 0, 1);
        fetch_req = 1'b0;
        vectors++;
        if (loaded !== 1'b1 || fetch_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL reload_valid got %b/%b want 1/1", loaded, fetch_valid);
        end else begin
            fexp = fq.pop_front();
            if (fetch_bytes !== fexp || fexp !== 24'h939495) begin
                miscompares++;
                $display("FAIL reload_fetch got %h want %h", fetch_bytes, fexp);
            end
        end
    endtask

    task automatic test_restart();
        start_load(16'h000A);
        send_data(8'h50, 0);
        send_data(8'h51, 1);
        load_start = 1'b1;
        load_valid = 1'b1;
        load_byte  = 8'h52;
        tick();
        load_start = 1'b0;
        load_valid = 1'b0;
        vectors++;
        if (loaded !== 1'b0 || load_count !== 5'd0) begin
            miscompares++;
            $display("FAIL restart_clear got %b/%0d want 0/0", loaded, load_count);
        end
        send_byte(8'h00);
        send_byte(8'h02);
        send_data(8'h11, 0);
        send_data(8'h22, 1);
        vectors++;
        if (loaded !== 1'b1 || load_count !== 5'd2) begin
            miscompares++;
            $display("FAIL restart_loaded got %b/%0d want 1/2", loaded, load_count);
        end
        issue(1, 0, 0, 0, 1);
        fetch_req = 1'b0;
        vectors++;
        if (fetch_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL restart_fetch_valid got %b want 1", fetch_valid);
        end else begin
            fexp = fq.pop_front();
            if (fetch_bytes !== fexp || fexp !== 24'h112292) begin
                miscompares++;
                $display("FAIL restart_fetch got %h want %h", fetch_bytes, fexp);
            end
        end
    endtask

    initial begin
        for (int i = 0; i < SIZE; i++) model[i] = 8'h00;
        test_reset();
        test_basic_load();
        test_back_to_back();
        test_overflow();
        test_no_queue();
        test_reset_mid();
        test_restart();
        vectors++;
        if (fq.size() != 0 || cq.size() != 0) begin
            miscompares++;
            $display("FAIL scoreboard_leftover got %0d/%0d want 0/0", fq.size(), cq.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
